// File: rtl/trivium_pkg.sv
// rtl/trivium_pkg.sv - Trivium sizes, tap positions, FSM encoding and state-load helper
package trivium_pkg;

    localparam int STATE_W         = 288;
    localparam int KEY_W           = 80;
    localparam int IV_W            = 80;
    localparam int INIT_ROUNDS_DEF = 1152;

    // Tap positions use the 1-based s1..s288 numbering of the cipher definition.
    localparam int TAP_T1_A   = 66;
    localparam int TAP_T1_B   = 93;
    localparam int TAP_T1_ANA = 91;
    localparam int TAP_T1_ANB = 92;
    localparam int TAP_T1_FB  = 171;
    localparam int TAP_T2_A   = 162;
    localparam int TAP_T2_B   = 177;
    localparam int TAP_T2_ANA = 175;
    localparam int TAP_T2_ANB = 176;
    localparam int TAP_T2_FB  = 264;
    localparam int TAP_T3_A   = 243;
    localparam int TAP_T3_B   = 288;
    localparam int TAP_T3_ANA = 286;
    localparam int TAP_T3_ANB = 287;
    localparam int TAP_T3_FB  = 69;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } fsm_t;

    // Bit i-1 of the vector holds s_i.
    function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
        logic [STATE_W-1:0] s;
        s          = '0;
        s[79:0]    = key;
        s[172:93]  = iv;
        s[287:285] = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_wide_core_if.sv
// rtl/trivium_wide_core_if.sv - data beat handshake between a stream source/sink and the cipher core
interface trivium_wide_core_if #(
    parameter int W = 32
) ();
    logic [W-1:0] dat_i;
    logic         dat_vld_i;
    logic         dat_rdy_o;
    logic [W-1:0] dat_o;
    logic         dat_vld_o;
    logic         dat_rdy_i;

    modport slave (
        input  dat_i,
        input  dat_vld_i,
        output dat_rdy_o,
        output dat_o,
        output dat_vld_o,
        input  dat_rdy_i
    );

    modport master (
        output dat_i,
        output dat_vld_i,
        input  dat_rdy_o,
        input  dat_o,
        input  dat_vld_o,
        output dat_rdy_i
    );
endinterface

// File: rtl/trivium_step.sv
// rtl/trivium_step.sv - combinational W-step unrolled Trivium state update and keystream
module trivium_step
    import trivium_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] state_nxt,
    output logic [W-1:0]       ks
);

    always_comb begin
        logic [STATE_W-1:0] st;
        logic               t1;
        logic               t2;
        logic               t3;
        st = state;
        ks = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        // ks[0] comes from the first step so the earliest bit lands in the LSB.
        for (int i = 0; i < W; i++) begin
            t1 = st[TAP_T1_A-1] ^ st[TAP_T1_B-1];
            t2 = st[TAP_T2_A-1] ^ st[TAP_T2_B-1];
            t3 = st[TAP_T3_A-1] ^ st[TAP_T3_B-1];
            ks[i] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (st[TAP_T1_ANA-1] & st[TAP_T1_ANB-1]) ^ st[TAP_T1_FB-1];
            t2 = t2 ^ (st[TAP_T2_ANA-1] & st[TAP_T2_ANB-1]) ^ st[TAP_T2_FB-1];
            t3 = t3 ^ (st[TAP_T3_ANA-1] & st[TAP_T3_ANB-1]) ^ st[TAP_T3_FB-1];
            st = {st[286:177], t2, st[175:93], t1, st[91:0], t3};
        end
        state_nxt = st;
    end

endmodule

// File: rtl/trivium_wide_core.sv
// rtl/trivium_wide_core.sv - W-bit-per-beat Trivium stream cipher with warm-up FSM and beat handshake
module trivium_wide_core
    import trivium_pkg::*;
#(
    parameter int W           = 32,
    parameter int INIT_ROUNDS = INIT_ROUNDS_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic [IV_W-1:0]  iv_i,
    input  logic             init_i,
    output logic             busy_init_o,
    trivium_wide_core_if.slave dat
);

    localparam int INIT_CYC = INIT_ROUNDS / W;
    localparam int CNT_W    = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

    fsm_t               fsm_q;
    fsm_t               fsm_d;
    logic [STATE_W-1:0] s_q;
    logic [STATE_W-1:0] s_nxt;
    logic [W-1:0]       ks;
    logic [CNT_W-1:0]   cnt_q;
    logic               cnt_done;
    logic               accept;

    trivium_step #(.W(W)) u_step (
        .state     (s_q),
        .state_nxt (s_nxt),
        .ks        (ks)
    );

    assign cnt_done      = (cnt_q == CNT_W'(INIT_CYC - 1));
    assign busy_init_o   = (fsm_q == ST_INIT);
    assign dat.dat_rdy_o = (fsm_q == ST_RUN) && (!dat.dat_vld_o || dat.dat_rdy_i);
    // A beat offered alongside init_i is never consumed, even though ready may be high.
    assign accept        = dat.dat_vld_i && dat.dat_rdy_o && !init_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        if (init_i) begin
            fsm_d = ST_INIT;
        end else begin
            case (fsm_q)
                ST_INIT: if (cnt_done) fsm_d = ST_RUN;
                default: fsm_d = fsm_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_q           <= '0;
            cnt_q         <= '0;
            dat.dat_o     <= '0;
            dat.dat_vld_o <= 1'b0;
        end else if (init_i) begin
            s_q           <= load_state(key_i, iv_i);
            cnt_q         <= '0;
            dat.dat_vld_o <= 1'b0;
        end else if (fsm_q == ST_INIT) begin
            s_q   <= s_nxt;
            cnt_q <= cnt_done ? '0 : cnt_q + CNT_W'(1);
        end else if (fsm_q == ST_RUN) begin
            if (accept) begin
                s_q           <= s_nxt;
                dat.dat_o     <= dat.dat_i ^ ks;
                dat.dat_vld_o <= 1'b1;
            end else if (dat.dat_rdy_i) begin
                dat.dat_vld_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/trivium_wide_core.md
TRIVIUM_WIDE_CORE -- requirements
Module: trivium_wide_core

Interface
REQ-001 SHALL have parameter W, default 32: keystream/data bits per accepted beat; legal values 1,2,4,8,16,32,64.
REQ-002 SHALL have parameter INIT_ROUNDS, default 1152: warm-up bit-steps; SHALL be a multiple of W.
REQ-003 SHALL have port clk_i, input, 1: single clock, rising-edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port key_i, input, 80: key; key_i[0] = K1.
REQ-006 SHALL have port iv_i, input, 80: IV; iv_i[0] = IV1.
REQ-007 SHALL have port init_i, input, 1: one-cycle pulse; samples key_i/iv_i and starts warm-up.
REQ-008 SHALL have port busy_init_o, output, 1: high while warm-up is in progress.
REQ-009 SHALL have port dat_i, input, W: plaintext/ciphertext beat; dat_i[0] is the earliest bit.
REQ-010 SHALL have port dat_vld_i, input, 1: input beat valid.
REQ-011 SHALL have port dat_rdy_o, output, 1: core accepts an input beat.
REQ-012 SHALL have port dat_o, output, W: dat_i XOR keystream; dat_o[0] = earliest keystream bit.
REQ-013 SHALL have port dat_vld_o, output, 1: output beat valid.
REQ-014 SHALL have port dat_rdy_i, input, 1: downstream accepts the output beat.

Function
REQ-015 SHALL implement a three-state FSM: IDLE -> INIT on init_i; INIT -> RUN when the warm-up counter expires; RUN -> INIT on init_i.
REQ-016 On init_i, SHALL load the 288-bit state as follows: s1..s80 = key, s81..s93 = 0; s94..s173 = IV, s174..s177 = 0; s178..s285 = 0, s286..s288 = 1.
REQ-017 In INIT, SHALL advance the state by W bit-steps per cycle, discard the output, and finish in exactly INIT_ROUNDS/W cycles (36 cycles for W=32).
REQ-018 busy_init_o SHALL be high from the cycle after init_i through the last INIT cycle, and low in the cycle the FSM enters RUN.
REQ-019 dat_rdy_o SHALL equal (state==RUN) && (!dat_vld_o || dat_rdy_i).
REQ-020 On accept (dat_vld_i && dat_rdy_o), SHALL register dat_o = dat_i XOR z[W-1:0], set dat_vld_o, and advance the state by W steps; latency is 1 cycle.
REQ-021 The state SHALL advance only on accept; a stalled beat SHALL hold dat_o, dat_vld_o and the cipher state unchanged.
REQ-022 dat_vld_o SHALL clear when dat_rdy_i is high and no new beat is accepted in the same cycle.
REQ-023 Simultaneous accept and output drain SHALL sustain full throughput of one beat per cycle.
REQ-024 init_i SHALL take priority over everything in any state: it aborts INIT or RUN, clears dat_vld_o, reloads the state and restarts the counter; input beats offered in that cycle SHALL NOT be accepted.
REQ-025 The keystream bit sequence SHALL be identical for every W; W only changes the grouping of bits into beats.
REQ-026 init_i while dat_vld_i is high in IDLE/INIT SHALL produce no output beat.

Reset
REQ-027 While rst_i is high: FSM = IDLE, state = all zeros, counter = 0, busy_init_o = 0, dat_rdy_o = 0, dat_vld_o = 0, dat_o = 0.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL abandon the operation; a new init_i is required after reset.

Structure
REQ-029 Package trivium_pkg SHALL hold STATE_W=288, KEY_W=80, IV_W=80, the default INIT_ROUNDS, the tap positions, and the FSM state enum.
REQ-030 A sub-module trivium_step SHALL implement the combinational W-step unrolled state update and keystream generation; trivium_wide_core holds the registers, FSM, counter and handshake.

Verification
REQ-031 Test 1: W=1 and W=32 instances, same key and IV, 64 zero beats (W=1) vs 2 beats (W=32) -> identical 64-bit keystream, equal to the C golden model.
REQ-032 Test 2: W=32, init_i pulse -> busy_init_o high for exactly 36 cycles, dat_rdy_o low throughout, first accept possible in cycle 37.
REQ-033 Test 3: dat_rdy_i held low for 5 cycles with dat_vld_i=1 -> dat_o stable, exactly one beat accepted; on release, the following beats match the model with no skipped keystream.
REQ-034 Test 4: encrypt 0xDEADBEEF, then re-init with the same key/IV and feed the ciphertext back in -> output 0xDEADBEEF.
REQ-035 Test 5: init_i asserted at INIT cycle 10 and at RUN beat 3 -> counter restarts, dat_vld_o clears, and the keystream restarts from z1 of the new key/IV.
REQ-036 Test 6: rst_i asserted mid-RUN -> all outputs zero next cycle, no beats accepted until a new init_i completes.
